fetch_issue_ctrl: RTL
=====================

// Module: fetch_issue_ctrl
// PURPOSE
//  Instruction fetch/issue controller sitting between program ROM, the program sequencer and the
//  FIR MAC datapath. Decodes each fetched word: loop-setup words drive the sequencer's loop
//  registers, I/O words stall the program on sample-in / result-out handshakes, and all other
//  words issue to the datapath. Owns program start/halt and the sequencer advance enable.
// PARAMETERS
//  INSTR_W  32  program word width; opcode [31:28], iter [27:16], size [11:0], dp field [27:0]
//  CNT_W    12  loop iter/size field width (matches sequencer)
// PORTS
//  clk       in   1        clock
//  reset     in   1        asynchronous, active-high reset
//  start     in   1        pulse: begin program at address 0 (ignored unless IDLE or HALTED)
//  busy      out  1        high in PRIME/RUN/WAIT_IN/WAIT_OUT
//  done      out  1        high in HALTED until next start
//  err       out  1        sticky: illegal opcode or LOOP with iter==0; cleared by start
//  seq_clr   out  1        one-cycle synchronous PC clear to sequencer
//  seq_en    out  1        sequencer advance enable; 0 holds address
//  seq_we    out  1        one-cycle loop-register write strobe to sequencer
//  seq_iter  out  CNT_W    loop iteration count (valid with seq_we)
//  seq_size  out  CNT_W    loop body size (valid with seq_we)
//  rom_data  in   INSTR_W  ROM word; synchronous ROM, data = mem[addr of previous cycle]
//  in_valid  in   1        input sample available
//  in_ready  out  1        accept sample (only in WAIT_IN)
//  dp_load   out  1        datapath captures input sample (= in_valid & in_ready)
//  out_valid out  1        datapath result valid to consumer (only in WAIT_OUT)
//  out_ready in   1        consumer accepts result
//  dp_valid  out  1        issue strobe for dp_instr
//  dp_instr  out  28       datapath operation field, registered
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; err 0. Reset mid-program aborts immediately, no drain.
//  Opcodes: 0 NOP, 1 LOOP, 2 WAIT_IN, 3 OUT, 4-7 EXEC (issue), F HALT, 8-E illegal.
//  IDLE --start--> seq_clr=1 for one cycle, -> PRIME. PRIME: seq_en=1, no decode (ROM latency),
//   -> RUN. RUN: seq_en=1 by default; decode rom_data each cycle:
//   NOP: nothing. EXEC: dp_valid=1 next cycle, dp_instr=rom_data[27:0] (1-cycle latency).
//   LOOP: seq_we=1 same cycle, seq_iter/seq_size = fields, passed unmodified; iter==0 -> err, HALTED.
//   WAIT_IN: seq_en=0 that cycle, -> WAIT_IN. OUT: seq_en=0, -> WAIT_OUT. HALT: seq_en=0, -> HALTED.
//   Illegal: err=1, seq_en=0, -> HALTED.
//  WAIT_IN: in_ready=1, seq_en=0, rom_data ignored; on in_valid: dp_load=1, seq_en=1, -> RUN.
//  WAIT_OUT: out_valid=1, seq_en=0; on out_ready: seq_en=1, -> RUN. out_valid never drops before ack.
//  Stall invariant: address held while stalled, so first RUN decode after resume sees the word
//   following the stalling instruction; no word skipped or duplicated.
//  HALTED: done=1, seq_en=0; start -> clears done/err, seq_clr, -> PRIME. start while busy ignored.
//  in_valid and out_ready are ignored outside their wait states; in_valid same cycle as WAIT_IN
//   decode is not consumed until the following cycle (WAIT_IN state).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_cycles[31:0] (busy cycles) and perf_stalls[31:0]
//   (cycles in WAIT_IN/WAIT_OUT); cleared on reset and start, saturate at all-ones.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package fir_isa_pkg: opcode localparams, instruction field bit positions, state enum
//   (IDLE, PRIME, RUN, WAIT_IN, WAIT_OUT, HALTED).
//  Sub-module fetch_decode: combinational opcode/field decode and illegal/iter==0 flag.
//  Top: state register, handshake logic, registered dp outputs, optional perf counters.
// TESTING
//  1 start; ROM {EXEC 0x1, EXEC 0x2, HALT} -> dp_valid 2 cycles, dp_instr 0x1 then 0x2; done=1.
//  2 LOOP iter=4 size=2 -> seq_we one cycle, seq_iter=4, seq_size=2, seq_en stays 1.
//  3 WAIT_IN, in_valid low 5 cycles -> seq_en=0, in_ready=1 for 5 cycles; in_valid -> dp_load 1 cycle.
//  4 OUT with out_ready held low 3 cycles -> out_valid stable 3+1 cycles, next EXEC issues after ack.
//  5 opcode 0x9 or LOOP iter=0 -> err=1, HALTED; start -> err=0, seq_clr pulse, PRIME.
//  6 reset asserted in WAIT_OUT -> all outputs 0 same cycle, IDLE; start while busy -> no effect.

Source files
------------

// File: rtl/fir_isa_pkg.sv
// FIR program ISA: opcode encodings, instruction field positions, controller state and
// decoded operation class shared by the fetch/issue controller and its decoder.
package fir_isa_pkg;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 28;
    localparam int unsigned ITER_LSB = 16;
    localparam int unsigned SIZE_LSB = 0;
    localparam int unsigned DP_MSB   = 27;
    localparam int unsigned DP_W     = 28;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_LOOP    = 4'h1;
    localparam logic [3:0] OP_WAIT_IN = 4'h2;
    localparam logic [3:0] OP_OUT     = 4'h3;
    localparam logic [3:0] OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_WAIT_IN,
        ST_WAIT_OUT,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LOOP,
        CLS_WAIT_IN,
        CLS_OUT,
        CLS_EXEC,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] opc);
        op_class_t cls;
        case (opc)
            OP_NOP:                    cls = CLS_NOP;
            OP_LOOP:                   cls = CLS_LOOP;
            OP_WAIT_IN:                cls = CLS_WAIT_IN;
            OP_OUT:                    cls = CLS_OUT;
            4'h4, 4'h5, 4'h6, 4'h7:    cls = CLS_EXEC;
            OP_HALT:                   cls = CLS_HALT;
            default:                   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational decode of one program word into operation class, loop fields, datapath
// field and a flag for words that must abort the program (illegal opcode, LOOP with iter 0).
module fetch_decode
    import fir_isa_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 12
) (
    input  logic [INSTR_W-1:0] instr,
    output op_class_t          op_class,
    output logic [CNT_W-1:0]   iter,
    output logic [CNT_W-1:0]   size,
    output logic [DP_W-1:0]    dp_field,
    output logic               bad
);

    always_comb begin
        op_class = classify(instr[OPC_MSB:OPC_LSB]);
        iter     = instr[ITER_LSB +: CNT_W];
        size     = instr[SIZE_LSB +: CNT_W];
        dp_field = instr[DP_MSB:0];
        bad      = (op_class == CLS_ILLEGAL) ||
                   ((op_class == CLS_LOOP) && (iter == '0));
    end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue controller between program ROM, sequencer and FIR MAC datapath.
// Optional FETCH_PERF_EN adds saturating busy/stall cycle counters.
module fetch_issue_ctrl
    import fir_isa_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               seq_clr,
    output logic               seq_en,
    output logic               seq_we,
    output logic [CNT_W-1:0]   seq_iter,
    output logic [CNT_W-1:0]   seq_size,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               dp_load,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               dp_valid,
    output logic [27:0]        dp_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stalls
`endif
);

    state_t           state;
    state_t           state_nxt;
    op_class_t        op_class;
    logic [CNT_W-1:0] dec_iter;
    logic [CNT_W-1:0] dec_size;
    logic [DP_W-1:0]  dec_dp;
    logic             dec_bad;
    logic             start_ok;
    logic             err_set;
    logic             issue;

    fetch_decode #(
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) u_decode (
        .instr    (rom_data),
        .op_class (op_class),
        .iter     (dec_iter),
        .size     (dec_size),
        .dp_field (dec_dp),
        .bad      (dec_bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            err      <= 1'b0;
            dp_valid <= 1'b0;
            dp_instr <= '0;
        end else begin
            state    <= state_nxt;
            dp_valid <= issue;
            if (issue)
                dp_instr <= dec_dp;
            if (start_ok)
                err <= 1'b0;
            else if (err_set)
                err <= 1'b1;
        end
    end

    // The sequencer address is held whenever seq_en is low, so the word after a stalling
    // instruction is still on rom_data when RUN resumes.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        err_set   = 1'b0;
        issue     = 1'b0;
        seq_clr   = 1'b0;
        seq_en    = 1'b0;
        seq_we    = 1'b0;
        seq_iter  = '0;
        seq_size  = '0;
        in_ready  = 1'b0;
        dp_load   = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    start_ok  = 1'b1;
                    seq_clr   = 1'b1;
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                seq_en    = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                seq_en = 1'b1;
                if (dec_bad) begin
                    seq_en    = 1'b0;
                    err_set   = 1'b1;
                    state_nxt = ST_HALTED;
                end else begin
                    case (op_class)
                        CLS_LOOP: begin
                            seq_we   = 1'b1;
                            seq_iter = dec_iter;
                            seq_size = dec_size;
                        end
                        CLS_EXEC: issue = 1'b1;
                        CLS_WAIT_IN: begin
                            seq_en    = 1'b0;
                            state_nxt = ST_WAIT_IN;
                        end
                        CLS_OUT: begin
                            seq_en    = 1'b0;
                            state_nxt = ST_WAIT_OUT;
                        end
                        CLS_HALT: begin
                            seq_en    = 1'b0;
                            state_nxt = ST_HALTED;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dp_load   = 1'b1;
                    seq_en    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_WAIT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    seq_en    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (state == ST_HALTED);
        busy = (state == ST_PRIME) || (state == ST_RUN) ||
               (state == ST_WAIT_IN) || (state == ST_WAIT_OUT);
    end

`ifdef FETCH_PERF_EN
    logic stalled;

    always_comb stalled = (state == ST_WAIT_IN) || (state == ST_WAIT_OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 32'd1;
            if (stalled && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
